// File: rtl/mfp_clock_divider_prog.sv
// -----------------------------------------------------------------------------
// mfp_clock_divider_prog
//
// Runtime-programmable clock divider. Counts a programmable half-period in clki
// cycles and toggles a registered divided clock (clko) each time the count
// completes, giving a 50%-duty output with period 2*half. A one-cycle strobe
// (clko_stb) marks every clko rising edge so downstream logic can stay in the
// clki domain. New divisors are queued and only take effect at a toggle, so an
// in-flight half-period is never shortened (no runt pulses).
//
// Optional feature macro: MFP_CLOCK_DIVIDER_STEP_EN
//   Defined     : while paused, a step request runs the divider for exactly one
//                 full clko period (two toggles), then freezes again.
//   Not defined : step is accepted but ignored; the divider runs whenever
//                 pause is low.
//
// Parameters
//   CNT_W        width of the half-period counter and divisor
//   DEFAULT_HALF half-period loaded at reset (must fit in CNT_W bits)
//
// Ports
//   clki       in   system clock, all logic on posedge
//   resetn     in   asynchronous active-low reset
//   div_in     in   new half-period value (0 behaves as 1)
//   div_load   in   one-cycle request to load div_in
//   div_busy   out  a load is pending; further div_load is ignored
//   pause      in   freeze divider (counter and clko hold)
//   step       in   single-period step request (step build only)
//   clko       out  divided clock, registered
//   clko_stb   out  one-cycle pulse in the cycle clko becomes 1
//   cur_half   out  half-period value currently in effect
//   step_state out  step controller state (0 idle, 1 first half, 2 second half)
// -----------------------------------------------------------------------------
module mfp_clock_divider_prog #(
  parameter int CNT_W        = 27,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic             clki,
  input  logic             resetn,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  input  logic             pause,
  input  logic             step,
  output logic             clko,
  output logic             clko_stb,
  output logic [CNT_W-1:0] cur_half,
  output logic [1:0]       step_state
);

  // Step controller states. IDLE means no step is in progress.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP_H1 = 2'd1,   // stepping, waiting for the first toggle
    ST_STEP_H2 = 2'd2    // stepping, waiting for the second toggle
  } step_state_t;

  localparam logic [CNT_W-1:0] DEFAULT_HALF_W = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE_W          = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cur_half_q;
  logic [CNT_W-1:0] pending_q;
  logic             busy_q;
  logic             clko_q;
  logic             clko_stb_q;

  step_state_t      st_q;
  step_state_t      st_d;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] eff_half;
  logic             step_act;
  logic             running;
  logic             toggle;
  logic             load_accept;

  // A programmed value of 0 behaves exactly like 1 (clko = clki/2).
  assign eff_half = (cur_half_q == '0) ? ONE_W : cur_half_q;

  assign step_act = (st_q != ST_IDLE);
  assign running  = !pause || step_act;

  // Toggle event: the current half-period has been fully counted. cur_half
  // only changes on a toggle (when cnt returns to 0), so cnt can never be
  // above eff_half-1 and an equality compare is sufficient.
  assign toggle = running && (cnt_q == (eff_half - ONE_W));

  // Load handshake: div_load is a single-cycle request, accepted only while
  // div_busy is low. div_busy rises the cycle after acceptance and stays high
  // until the pending value is applied at a later toggle; requests arriving
  // while div_busy is high are dropped silently. Because acceptance requires
  // div_busy low and application requires it high, a load accepted in the
  // same cycle as a toggle is applied at the following toggle, not this one.
  assign load_accept = div_load && !busy_q;

  // ---------------------------------------------------------------------------
  // Counter, divided clock, strobe and divisor update
  // ---------------------------------------------------------------------------
  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      cur_half_q <= DEFAULT_HALF_W;
      pending_q  <= '0;
      busy_q     <= 1'b0;
      clko_q     <= 1'b0;
      clko_stb_q <= 1'b0;
    end else begin
      clko_stb_q <= 1'b0;

      if (running) begin
        if (toggle) begin
          cnt_q      <= '0;
          clko_q     <= ~clko_q;
          // Strobe only for the 0->1 transition of clko.
          clko_stb_q <= ~clko_q;
          // A pending divisor governs the half-period starting now.
          if (busy_q) begin
            cur_half_q <= pending_q;
            busy_q     <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + ONE_W;
        end
      end

      if (load_accept) begin
        pending_q <= div_in;
        busy_q    <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step controller
  // ---------------------------------------------------------------------------
`ifdef MFP_CLOCK_DIVIDER_STEP_EN

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // A step runs through exactly two toggles (one full clko period). Dropping
  // pause mid-step does not restart or extend it: the step simply completes
  // at its second toggle while the divider keeps running freely.
  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: begin
        if (pause && step) begin
          st_d = ST_STEP_H1;
        end
      end
      ST_STEP_H1: begin
        if (toggle) begin
          st_d = ST_STEP_H2;
        end
      end
      ST_STEP_H2: begin
        if (toggle) begin
          st_d = ST_IDLE;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

`else

  // No step support: the controller is permanently idle and step is unused.
  logic step_unused;
  assign step_unused = step;

  always_comb begin
    st_d = ST_IDLE;
  end

  assign st_q = st_d;

`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign div_busy   = busy_q;
  assign clko       = clko_q;
  assign clko_stb   = clko_stb_q;
  assign cur_half   = cur_half_q;
  assign step_state = st_q;

endmodule

// File: tb/tb_mfp_clock_divider_prog.sv
// -----------------------------------------------------------------------------
// Testbench for mfp_clock_divider_prog (CNT_W=8, DEFAULT_HALF=4).
// A countdown-style behavioural model tracks how many running cycles remain
// in the current half-period; it is compared against the DUT every cycle.
// A directed prologue pins the model with hand-computed values, then a long
// randomized run with loads, pauses, steps and async resets follows.
// -----------------------------------------------------------------------------
module tb_mfp_clock_divider_prog;

  localparam int CNT_W        = 8;
  localparam int DEFAULT_HALF = 4;

`ifdef MFP_CLOCK_DIVIDER_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clki;
  logic             resetn;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic             pause;
  logic             step;
  logic             clko;
  logic             clko_stb;
  logic [CNT_W-1:0] cur_half;
  logic [1:0]       step_state;

  initial clki = 1'b0;
  always #5 clki = ~clki;

  mfp_clock_divider_prog #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DEFAULT_HALF)
  ) dut (
    .clki       (clki),
    .resetn     (resetn),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_busy   (div_busy),
    .pause      (pause),
    .step       (step),
    .clko       (clko),
    .clko_stb   (clko_stb),
    .cur_half   (cur_half),
    .step_state (step_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_pass;
  int cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: half-periods as countdowns of running cycles
  // ---------------------------------------------------------------------------
  int m_rem;       // running cycles left until the next toggle
  bit m_clko;
  bit m_stb;
  int m_cur;       // half-period in effect
  bit m_busy;
  int m_pend;
  int m_steps;     // toggles still owed to an active step (0 = none)

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic model_reset();
    m_cur   = DEFAULT_HALF;
    m_rem   = eff(DEFAULT_HALF);
    m_clko  = 1'b0;
    m_stb   = 1'b0;
    m_busy  = 1'b0;
    m_pend  = 0;
    m_steps = 0;
  endtask

  // One clki rising edge with the given inputs.
  task automatic model_edge(input bit ld, input int din, input bit pz, input bit st);
    bit run;
    bit busy_before;
    bit start_step;
    run         = !pz || (m_steps > 0);
    busy_before = m_busy;
    start_step  = STEP_EN && (m_steps == 0) && pz && st;
    m_stb       = 1'b0;
    if (run) begin
      if (m_rem == 1) begin
        m_clko = !m_clko;
        m_stb  = m_clko;
        if (busy_before) begin
          m_cur  = m_pend;
          m_busy = 1'b0;
        end
        m_rem = eff(m_cur);
        if (m_steps > 0) m_steps--;
      end else begin
        m_rem--;
      end
    end
    if (ld && !busy_before) begin
      m_pend = din;
      m_busy = 1'b1;
    end
    if (start_step) m_steps = 2;
  endtask

  task automatic compare_all();
    chk("clko",       32'(clko),     32'(m_clko));
    chk("clko_stb",   32'(clko_stb), 32'(m_stb));
    chk("div_busy",   32'(div_busy), 32'(m_busy));
    chk("cur_half",   32'(cur_half), 32'(m_cur));
    chk("step_active", 32'(step_state != 2'd0), 32'(m_steps > 0));
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    div_load = 1'b0;
    div_in   = '0;
    step     = 1'b0;
  endtask

  // Advance one edge: DUT and model see the same inputs; compare at negedge.
  task automatic tick();
    @(posedge clki);
    model_edge(div_load, int'(div_in), pause, step);
    cyc++;
    @(negedge clki);
    compare_all();
  endtask

  task automatic do_async_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_clko",     32'(clko),       32'd0);
    chk("rst_clko_stb", 32'(clko_stb),   32'd0);
    chk("rst_div_busy", 32'(div_busy),   32'd0);
    chk("rst_cur_half", 32'(cur_half),   32'd4);
    chk("rst_step",     32'(step_state), 32'd0);
    #1;
    resetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    resetn   = 1'b0;
    pause    = 1'b0;
    drive_idle();
    model_reset();

    @(negedge clki);
    @(negedge clki);
    do_async_reset();

    // Directed prologue: half=4 free-running, then a load of 2 and an
    // ignored load of 7 while busy.
    for (int i = 1; i <= 34; i++) begin
      drive_idle();
      if (i == 26) begin
        div_load = 1'b1;
        div_in   = 8'd2;
      end
      if (i == 27) begin
        div_load = 1'b1;
        div_in   = 8'd7;
      end
      tick();
      if (cyc <= 24) begin
        chk("lit_stb",  32'(clko_stb), 32'((cyc == 4) || (cyc == 12) || (cyc == 20)));
        chk("lit_clko", 32'(clko),     32'((cyc / 4) % 2));
      end
      if (cyc == 26) chk("lit_busy_after_load", 32'(div_busy), 32'd1);
      if (cyc == 27) chk("lit_cur_half_held",   32'(cur_half), 32'd4);
      if (cyc == 28) begin
        chk("lit_cur_half_applied", 32'(cur_half), 32'd2);
        chk("lit_busy_cleared",     32'(div_busy), 32'd0);
        chk("lit_stb_28",           32'(clko_stb), 32'd1);
      end
      if (cyc == 30) chk("lit_clko_fall_30", 32'(clko),     32'd0);
      if (cyc == 32) chk("lit_stb_32",       32'(clko_stb), 32'd1);
      if (cyc == 34) chk("lit_cur_half_end", 32'(cur_half), 32'd2);
    end

    // Directed pause: freeze for 10 cycles, then resume.
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_idle();
      tick();
      chk("lit_pause_stb", 32'(clko_stb), 32'd0);
    end
    pause = 1'b0;

    // Directed divisor 0: after apply, clko toggles every cycle.
    drive_idle();
    div_load = 1'b1;
    div_in   = 8'd0;
    tick();
    for (int i = 0; i < 12; i++) begin
      drive_idle();
      tick();
    end
    chk("lit_cur_half_zero", 32'(cur_half), 32'd0);

    // Randomized phase.
    for (int i = 0; i < 6000; i++) begin
      drive_idle();
      if ($urandom_range(0, 24) == 0) pause = !pause;
      if ($urandom_range(0, 7) == 0)  step = 1'b1;
      if ($urandom_range(0, 11) == 0) begin
        div_load = 1'b1;
        div_in   = 8'($urandom_range(0, 6));
      end
      if ((i % 1500) == 777) begin
        do_async_reset();
        cyc = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
